// File: rtl/button_color_encoder.sv
// Debounced 4-button to 2-bit colour encoder; ColorValid rises DEBOUNCE_CYCLES+3 cycles after a clean press.
// ColorValid/ColorCode hold until ColorReady; optional registered ColorRgb echo under `SS_RGB_ECHO_EN.
module button_color_encoder #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic [3:0]  ButtonIn,
  input  logic        Enable,
  input  logic        ColorReady,
  output logic [1:0]  ColorCode,
  output logic        ColorValid,
  output logic        PressActive,
`ifdef SS_RGB_ECHO_EN
  output logic [11:0] ColorRgb,
`endif
  output logic        MultiPress
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       cap_q, cap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       code_q, code_d;
  logic             valid_q, valid_d;
  logic             active_q, active_d;
  logic             multi_q, multi_d;

  logic [3:0] s;
  logic       s_zero, s_one_hot, s_multi, s_same, s_superset, cnt_last;

  assign s          = sync2_q;
  assign s_zero     = (s == 4'b0000);
  assign s_one_hot  = !s_zero && ((s & (s - 4'd1)) == 4'b0000);
  assign s_multi    = !s_zero && !s_one_hot;
  assign s_same     = (s == cap_q);
  assign s_superset = ((s & cap_q) == cap_q) && !s_same;
  assign cnt_last   = (cnt_q == CNT_LAST);

  function automatic logic [1:0] encode(input logic [3:0] oh);
    case (oh)
      4'b0010: encode = 2'd1;
      4'b0100: encode = 2'd2;
      4'b1000: encode = 2'd3;
      default: encode = 2'd0;
    endcase
  endfunction

  always_comb begin
    sync1_d  = ButtonIn;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cap_d    = cap_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    valid_d  = valid_q && !ColorReady;
    multi_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Enable && s_multi) begin
          multi_d = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end else if (Enable && !valid_q && s_one_hot) begin
          // A pending code blocks new captures so ColorCode stays stable.
          cap_d   = s;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!Enable || s_zero) begin
          state_d = IDLE;
        end else if (s_same) begin
          if (cnt_last) begin
            state_d = HELD;
            valid_d = 1'b1;
            code_d  = encode(cap_q);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (s_superset) begin
          multi_d = 1'b1;
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end else begin
          // Switched to a different button: restart from IDLE.
          state_d = IDLE;
        end
      end
      HELD: begin
        if (!s_same) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
      end
      RELEASE_WAIT: begin
        if (!s_zero) begin
          cnt_d = '0;
        end else if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == HELD);
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      cap_q    <= '0;
      cnt_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      cap_q    <= cap_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      active_q <= active_d;
      multi_q  <= multi_d;
    end
  end

  assign ColorCode   = code_q;
  assign ColorValid  = valid_q;
  assign PressActive = active_q;
  assign MultiPress  = multi_q;

`ifdef SS_RGB_ECHO_EN
  logic [11:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d = 12'h000;
    if (state_d == HELD) begin
      case (cap_d)
        4'b0001: rgb_d = 12'hF00;
        4'b0010: rgb_d = 12'h0F0;
        4'b0100: rgb_d = 12'h00F;
        4'b1000: rgb_d = 12'hFF0;
        default: rgb_d = 12'h000;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rgb_q <= 12'h000;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign ColorRgb = rgb_q;
`endif

endmodule
